dcache_ctrl: RTL

//  Direct-mapped, write-back, write-allocate data cache between pipeline memory stage and line RAM.
//  CPU side: 64-bit little-endian loads/stores. Memory side: 256-bit (32-byte) line transfers.

---
 rtl/dcache_pkg.sv | 26 ++
 rtl/dcache_line_store.sv | 62 ++++++
 rtl/dcache_ctrl.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/dcache_pkg.sv
// Shared types and address-field helpers for the direct-mapped data cache.
package dcache_pkg;

    typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE, ERR} state_t;

    localparam int LINE_BYTES = 32;
    localparam int OFFSET_W   = 5;
    localparam int LINE_W     = LINE_BYTES * 8;
    localparam int WORD_BYTES = 8;

    // An 8-byte access starting past this offset would spill into the next line.
    function automatic logic crosses_line(input logic [OFFSET_W-1:0] off);
        return off > OFFSET_W'(LINE_BYTES - WORD_BYTES);
    endfunction

    function automatic logic [OFFSET_W+2:0] word_shift(input logic [OFFSET_W-1:0] off);
        return {off, 3'b000};
    endfunction

    function automatic logic [LINE_BYTES-1:0] byte_lane_mask(input logic [OFFSET_W-1:0] off);
        logic [LINE_BYTES-1:0] m;
        m = {{(LINE_BYTES-WORD_BYTES){1'b0}}, {WORD_BYTES{1'b1}}};
        return m << off;
    endfunction

endpackage

// File: rtl/dcache_line_store.sv
// Tag/valid/dirty/data storage: combinational read by index, one write port
// with per-byte data enables plus independent tag, valid and dirty updates.
module dcache_line_store
    import dcache_pkg::*;
#(
    parameter int NUM_LINES = 16,
    parameter int INDEX_W   = $clog2(NUM_LINES),
    parameter int TAG_W     = 55
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [INDEX_W-1:0]    rd_idx,
    output logic [TAG_W-1:0]      rd_tag,
    output logic                  rd_valid,
    output logic                  rd_dirty,
    output logic [LINE_W-1:0]     rd_data,
    input  logic [INDEX_W-1:0]    wr_idx,
    input  logic [LINE_BYTES-1:0] wr_be,
    input  logic [LINE_W-1:0]     wr_data,
    input  logic                  tag_we,
    input  logic [TAG_W-1:0]      wr_tag,
    input  logic                  valid_we,
    input  logic                  valid_d,
    input  logic                  dirty_we,
    input  logic                  dirty_d
);

    logic [NUM_LINES-1:0] valid_reg;
    logic [NUM_LINES-1:0] dirty_reg;
    logic [TAG_W-1:0]     tag_mem [NUM_LINES];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            valid_reg <= '0;
            dirty_reg <= '0;
        end else begin
            if (valid_we) valid_reg[wr_idx] <= valid_d;
            if (dirty_we) dirty_reg[wr_idx] <= dirty_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (tag_we) tag_mem[wr_idx] <= wr_tag;
    end

    // One storage array per byte lane so stores touch only their 8 lanes.
    genvar gi;
    generate
        for (gi = 0; gi < LINE_BYTES; gi++) begin : g_lane
            logic [7:0] lane_mem [NUM_LINES];
            always_ff @(posedge clk_i) begin
                if (wr_be[gi]) lane_mem[wr_idx] <= wr_data[gi*8 +: 8];
            end
            assign rd_data[gi*8 +: 8] = lane_mem[rd_idx];
        end
    endgenerate

    assign rd_tag   = tag_mem[rd_idx];
    assign rd_valid = valid_reg[rd_idx];
    assign rd_dirty = dirty_reg[rd_idx];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate data cache: 64-bit CPU port,
// 256-bit line port to the line RAM; zero-cycle hits, FSM-driven misses.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int NUM_LINES = 16,
    parameter int ADDR_W    = 64
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              cpu_valid_i,
    input  logic              cpu_rw_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [63:0]       cpu_wdata_i,
    output logic [63:0]       cpu_rdata_o,
    output logic              cpu_ready_o,
    output logic              cpu_error_o,
    output logic              mem_valid_o,
    output logic              mem_rw_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0] mem_wdata_o,
    input  logic [LINE_W-1:0] mem_rdata_i,
    input  logic              mem_ready_i,
    input  logic              mem_error_i
);

    localparam int INDEX_W = $clog2(NUM_LINES);
    localparam int TAG_W   = ADDR_W - INDEX_W - OFFSET_W;

    state_t              state_reg;
    logic [INDEX_W-1:0]  req_idx_reg;
    logic [TAG_W-1:0]    req_tag_reg;
    logic                mem_valid_reg, mem_rw_reg, err_reg;
    logic [ADDR_W-1:0]   mem_addr_reg;
    logic [LINE_W-1:0]   mem_wdata_reg;

    logic [OFFSET_W-1:0] cpu_off;
    logic [INDEX_W-1:0]  cpu_idx;
    logic [TAG_W-1:0]    cpu_tag;
    logic [OFFSET_W+2:0] shamt;
    logic                idle_req, misaligned, hit, miss;

    logic [TAG_W-1:0]      rd_tag;
    logic                  rd_valid, rd_dirty;
    logic [LINE_W-1:0]     rd_data;
    logic [INDEX_W-1:0]    wr_idx;
    logic [LINE_BYTES-1:0] wr_be;
    logic [LINE_W-1:0]     wr_data;
    logic                  tag_we, valid_we, valid_d, dirty_we, dirty_d;

    assign cpu_off = cpu_addr_i[OFFSET_W-1:0];
    assign cpu_idx = cpu_addr_i[OFFSET_W +: INDEX_W];
    assign cpu_tag = cpu_addr_i[ADDR_W-1:OFFSET_W+INDEX_W];
    assign shamt   = word_shift(cpu_off);

    assign idle_req   = (state_reg == IDLE) && cpu_valid_i;
    assign misaligned = idle_req && crosses_line(cpu_off);
    assign hit        = idle_req && !misaligned && rd_valid && (rd_tag == cpu_tag);
    assign miss       = idle_req && !misaligned && !hit;

    assign cpu_ready_o = hit;
    assign cpu_error_o = misaligned || err_reg;
    assign cpu_rdata_o = (hit && !cpu_rw_i) ? 64'(rd_data >> shamt) : '0;
    assign mem_valid_o = mem_valid_reg;
    assign mem_rw_o    = mem_rw_reg;
    assign mem_addr_o  = mem_addr_reg;
    assign mem_wdata_o = mem_wdata_reg;

    dcache_line_store #(
        .NUM_LINES (NUM_LINES),
        .INDEX_W   (INDEX_W),
        .TAG_W     (TAG_W)
    ) u_store (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .rd_idx   (cpu_idx),
        .rd_tag   (rd_tag),
        .rd_valid (rd_valid),
        .rd_dirty (rd_dirty),
        .rd_data  (rd_data),
        .wr_idx   (wr_idx),
        .wr_be    (wr_be),
        .wr_data  (wr_data),
        .tag_we   (tag_we),
        .wr_tag   (req_tag_reg),
        .valid_we (valid_we),
        .valid_d  (valid_d),
        .dirty_we (dirty_we),
        .dirty_d  (dirty_d)
    );

    // A failed fill leaves the index invalid so a retry misses again.
    always_comb begin
        wr_idx   = req_idx_reg;
        wr_be    = '0;
        wr_data  = mem_rdata_i;
        tag_we   = 1'b0;
        valid_we = 1'b0;
        valid_d  = 1'b0;
        dirty_we = 1'b0;
        dirty_d  = 1'b0;
        case (state_reg)
            IDLE: if (hit && cpu_rw_i) begin
                wr_idx   = cpu_idx;
                wr_be    = byte_lane_mask(cpu_off);
                wr_data  = LINE_W'(cpu_wdata_i) << shamt;
                dirty_we = 1'b1;
                dirty_d  = 1'b1;
            end
            WRITEBACK: if (mem_ready_i && !mem_error_i) dirty_we = 1'b1;
            ALLOCATE: if (mem_error_i) begin
                valid_we = 1'b1;
            end else if (mem_ready_i) begin
                wr_be    = '1;
                tag_we   = 1'b1;
                valid_we = 1'b1;
                valid_d  = 1'b1;
                dirty_we = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_reg     <= IDLE;
            req_idx_reg   <= '0;
            req_tag_reg   <= '0;
            mem_valid_reg <= 1'b0;
            mem_rw_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            err_reg       <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: if (miss) begin
                    req_idx_reg   <= cpu_idx;
                    req_tag_reg   <= cpu_tag;
                    mem_valid_reg <= 1'b1;
                    if (rd_valid && rd_dirty) begin
                        state_reg     <= WRITEBACK;
                        mem_rw_reg    <= 1'b1;
                        mem_addr_reg  <= {rd_tag, cpu_idx, {OFFSET_W{1'b0}}};
                        mem_wdata_reg <= rd_data;
                    end else begin
                        state_reg    <= ALLOCATE;
                        mem_rw_reg   <= 1'b0;
                        mem_addr_reg <= {cpu_tag, cpu_idx, {OFFSET_W{1'b0}}};
                    end
                end
                WRITEBACK: if (mem_error_i) begin
                    state_reg     <= ERR;
                    mem_valid_reg <= 1'b0;
                    err_reg       <= 1'b1;
                end else if (mem_ready_i) begin
                    state_reg    <= ALLOCATE;
                    mem_rw_reg   <= 1'b0;
                    mem_addr_reg <= {req_tag_reg, req_idx_reg, {OFFSET_W{1'b0}}};
                end
                ALLOCATE: if (mem_error_i) begin
                    state_reg     <= ERR;
                    mem_valid_reg <= 1'b0;
                    err_reg       <= 1'b1;
                end else if (mem_ready_i) begin
                    state_reg     <= IDLE;
                    mem_valid_reg <= 1'b0;
                end
                ERR: begin
                    state_reg <= IDLE;
                    err_reg   <= 1'b0;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
